axo_csr_file: RTL and testbench
===============================

Name: axo_csr_file

Overview:
Machine-mode CSR responder for the Axolotl core. The core sends a CSR access, and this block returns the old value and commits the new value. The new value is computed internally by an axo_csr_helper instance from funct3 and the operand. The block also holds trap state (mepc/mcause/mtval/mstatus) and the 64-bit cycle/instret counters, and drives trap-vector and interrupt-enable outputs to the fetch/trap logic.

Parameters:
XLEN, 32, register width; only 32 supported (counters split into low/high halves).
MISA, 32'h40001100, reset/read value of misa (RV32IM).
HARTID, 0, value returned by mhartid.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req  in  1  access request; held until ack.
we  in  1  access writes (0 for CSRRS/CSRRC with rs1=x0/zero imm).
addr  in  12  CSR address.
funct3  in  3  SYSTEM funct3, passed to axo_csr_helper.
operand  in  XLEN  rs1 value or zero-extended uimm.
privilege  in  2  current privilege level.
ack  out  1  one-cycle response strobe.
err  out  1  valid with ack; access illegal.
rdata  out  XLEN  old CSR value, valid with ack.
retire  in  1  one instruction retired this cycle.
trap  in  1  trap entry pulse.
trap_cause  in  XLEN  mcause value on trap.
trap_pc  in  XLEN  mepc value on trap.
trap_tval  in  XLEN  mtval value on trap.
mret  in  1  mret executed pulse.
mtvec_out  out  XLEN  current mtvec.
mepc_out  out  XLEN  current mepc.
irq_en  out  1  mstatus.MIE.

Behaviour:
- Reset (clk edge with rst=1): all CSRs are 0, except misa=MISA and mstatus.MPP=2'b11. Outputs ack=0, err=0, rdata=0. FSM returns to IDLE. An in-flight access is dropped and no ack is given.
- FSM has two states: IDLE and RESP.
  - IDLE with req=1: sample addr, check legality, capture old value into rdata, and commit write at this edge if legal and we=1. Go to RESP.
  - RESP: ack=1 for exactly one cycle, then IDLE. req is ignored in RESP.
  - Throughput is one access per 2 cycles. Latency is req-sampled edge to ack 1 cycle.
- Legality: err=1 if any of the following hold:
  - unimplemented address;
  - addr[9:8] > privilege;
  - we=1 and addr[11:10]==2'b11 (read-only).
  - On err: no state change, rdata=0.
- Implemented CSRs:
  - mstatus: MIE bit 3, MPIE bit 7, MPP bits 12:11. Other bits read 0. MPP is WARL: only 00/11 are stored, and a write of 01/10 keeps the old MPP.
  - misa: writes ignored, no err.
  - mie, mscratch, mcause, mtval: full width.
  - mtvec: bits 1:0 read 0.
  - mepc: bit 0 reads 0.
  - mip: reads 0, writes ignored.
  - mcycle/mcycleh (B00/B80), minstret/minstreth (B02/B82).
  - cycle/cycleh/instret/instreth (C00/C80/C02/C82): read-only shadows.
  - mvendorid/marchid/mimpid read 0; mhartid reads HARTID.
- Counters:
  - mcycle increments every non-reset cycle.
  - minstret increments when retire=1.
  - Both are 64-bit and wrap from all-ones to 0; the carry propagates from the low half to the high half.
  - A CSR write to either half at the same edge takes priority for the whole counter that edge: written half = new value, other half unchanged, no increment.
- Trap entry (trap=1):
  - mepc<=trap_pc with bit 0 cleared; mcause<=trap_cause; mtval<=trap_tval.
  - MPIE<=MIE; MIE<=0; MPP<=privilege (WARL-mapped: 11 stays 11, else 00).
- mret=1: MIE<=MPIE; MPIE<=1; MPP<=00.
- Simultaneous events:
  - trap and mret together: trap wins.
  - trap/mret coinciding with a CSR write commit to an affected CSR: trap/mret wins for the fields it updates, and the access still acks normally with the old value.
- mtvec_out, mepc_out and irq_en reflect registered state (the new value is visible the cycle after the update).

Test Plan:
- Reset, then read mcycle 3 cycles later -> ack with err=0. rdata equals the cycle count since reset deassertion (e.g. 2 if req is sampled at the third edge). misa read returns 32'h40001100.
- CSRRW mscratch with operand 32'hDEADBEEF -> rdata=0. A following CSRRS read with we=0 returns 32'hDEADBEEF. CSRRC with operand 32'h0000FFFF then leaves 32'hDEAD0000.
- Write to cycle (C00) with we=1 -> ack with err=1, rdata=0, state unchanged. Read of mstatus at privilege=00 -> err=1.
- Set mcycle=32'hFFFFFFFF, mcycleh=0 -> two cycles later mcycleh reads 1 and mcycle reads 1. A write to minstret coinciding with retire=1 stores the written value, not +1.
- mstatus.MIE=1, trap with cause 32'h0000000B, pc 32'h00001235 -> mepc_out=32'h00001234, irq_en=0, MPIE=1. mret then gives irq_en=1 and MPP=00.
- Assert rst while in RESP -> no ack the next cycle, mscratch reads 0 afterwards, and a new req completes normally.

Source files
------------

// File: rtl/axo_csr_if.sv
// CSR access channel between the Axolotl core (master) and the machine-mode CSR file (slave).
// One request is held until the single-cycle ack that carries err and the old CSR value.
interface axo_csr_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [11:0]     addr;
   logic [2:0]      funct3;
   logic [XLEN-1:0] operand;
   logic [1:0]      privilege;
   logic            ack;
   logic            err;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, we, addr, funct3, operand, privilege,
      input  ack, err, rdata
   );

   modport slave (
      input  req, we, addr, funct3, operand, privilege,
      output ack, err, rdata
   );
endinterface

// File: rtl/axo_csr_file.sv
// Machine-mode CSR file for the Axolotl core: two-state access responder, trap state,
// 64-bit cycle/instret counters, and trap-vector / interrupt-enable outputs.

module axo_csr_helper #(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] old_value,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] new_value
);
   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      new_value = old_value;
      case (funct3)
         3'b001, 3'b101: new_value = operand;
         3'b010, 3'b110: new_value = old_value | operand;
         3'b011, 3'b111: new_value = old_value & ~operand;
         default:        new_value = old_value;
      endcase
   end
endmodule

module axo_csr_file #(
   parameter int              XLEN   = 32,
   parameter logic [XLEN-1:0] MISA   = 32'h40001100,
   parameter int unsigned     HARTID = 0
) (
   input  logic            clk,
   input  logic            rst,
   axo_csr_if.slave        bus,
   input  logic            retire,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   output logic [XLEN-1:0] mtvec_out,
   output logic [XLEN-1:0] mepc_out,
   output logic            irq_en
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;

   logic [0:0]      state;
   logic            mie_bit, mpie_bit;
   logic [1:0]      mpp;
   logic [XLEN-1:0] mie_reg, mscratch, mtvec, mepc, mcause, mtval;
   logic [63:0]     mcycle, minstret;
   logic [XLEN-1:0] mstatus_val, old_value, new_value;
   logic            hit, legal, commit;

   axo_csr_helper #(.XLEN(XLEN)) u_helper (
      .funct3    (bus.funct3),
      .old_value (old_value),
      .operand   (bus.operand),
      .new_value (new_value)
   );

   always_comb begin
      mstatus_val        = '0;
      mstatus_val[3]     = mie_bit;
      mstatus_val[7]     = mpie_bit;
      mstatus_val[12:11] = mpp;
   end

   // Cycle/instret user shadows alias the machine counters; their writes are rejected by legality.
   always_comb begin
      hit       = 1'b1;
      old_value = '0;
      case (bus.addr)
         12'h300:                   old_value = mstatus_val;
         12'h301:                   old_value = MISA;
         12'h304:                   old_value = mie_reg;
         12'h305:                   old_value = mtvec;
         12'h340:                   old_value = mscratch;
         12'h341:                   old_value = mepc;
         12'h342:                   old_value = mcause;
         12'h343:                   old_value = mtval;
         12'h344:                   old_value = '0;
         12'hB00, 12'hC00:          old_value = mcycle[31:0];
         12'hB80, 12'hC80:          old_value = mcycle[63:32];
         12'hB02, 12'hC02:          old_value = minstret[31:0];
         12'hB82, 12'hC82:          old_value = minstret[63:32];
         12'hF11, 12'hF12, 12'hF13: old_value = '0;
         12'hF14:                   old_value = XLEN'(HARTID);
         default:                   hit = 1'b0;
      endcase
   end

   assign legal  = hit && (bus.addr[9:8] <= bus.privilege) && !(bus.we && bus.addr[11:10] == 2'b11);
   assign commit = (state == IDLE) && bus.req && legal && bus.we;

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bus.ack   <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ack <= 1'b0;
         case (state)
            IDLE: if (bus.req) begin
               state     <= RESP;
               bus.ack   <= 1'b1;
               bus.err   <= !legal;
               bus.rdata <= legal ? old_value : '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Trap entry beats mret, and both beat a same-edge CSR write to the fields they touch.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_bit  <= 1'b0;
         mpie_bit <= 1'b0;
         mpp      <= 2'b11;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (trap) begin
         mepc     <= trap_pc & ~XLEN'(1);
         mcause   <= trap_cause;
         mtval    <= trap_tval;
         mpie_bit <= mie_bit;
         mie_bit  <= 1'b0;
         mpp      <= (bus.privilege == 2'b11) ? 2'b11 : 2'b00;
      end else begin
         if (mret) begin
            mie_bit  <= mpie_bit;
            mpie_bit <= 1'b1;
            mpp      <= 2'b00;
         end else if (commit && bus.addr == 12'h300) begin
            mie_bit  <= new_value[3];
            mpie_bit <= new_value[7];
            if (new_value[12:11] == 2'b00 || new_value[12:11] == 2'b11) mpp <= new_value[12:11];
         end
         if (commit && bus.addr == 12'h341) mepc   <= new_value & ~XLEN'(1);
         if (commit && bus.addr == 12'h342) mcause <= new_value;
         if (commit && bus.addr == 12'h343) mtval  <= new_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_reg  <= '0;
         mscratch <= '0;
         mtvec    <= '0;
      end else if (commit) begin
         if (bus.addr == 12'h304) mie_reg  <= new_value;
         if (bus.addr == 12'h340) mscratch <= new_value;
         if (bus.addr == 12'h305) mtvec    <= new_value & ~XLEN'(3);
      end
   end

   // A write to either counter half suppresses that counter's increment for the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (commit && bus.addr == 12'hB00)      mcycle[31:0]  <= new_value;
         else if (commit && bus.addr == 12'hB80) mcycle[63:32] <= new_value;
         else                                    mcycle        <= mcycle + 64'd1;

         if (commit && bus.addr == 12'hB02)      minstret[31:0]  <= new_value;
         else if (commit && bus.addr == 12'hB82) minstret[63:32] <= new_value;
         else if (retire)                        minstret        <= minstret + 64'd1;
      end
   end

   assign mtvec_out = mtvec;
   assign mepc_out  = mepc;
   assign irq_en    = mie_bit;
endmodule

// File: tb/tb_axo_csr_file.sv
// Self-checking bench for axo_csr_file: directed scenarios plus randomized accesses
// compared against a behavioural CSR model kept in the bench.
module tb_axo_csr_file;
   localparam logic [31:0] MISA_V = 32'h40001100;
   localparam int unsigned HART   = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        retire, trap, mret;
   logic [31:0] trap_cause, trap_pc, trap_tval;
   logic [31:0] mtvec_out, mepc_out;
   logic        irq_en;

   axo_csr_if #(.XLEN(32)) bus ();

   axo_csr_file #(.XLEN(32), .MISA(MISA_V), .HARTID(HART)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .retire     (retire),
      .trap       (trap),
      .trap_cause (trap_cause),
      .trap_pc    (trap_pc),
      .trap_tval  (trap_tval),
      .mret       (mret),
      .mtvec_out  (mtvec_out),
      .mepc_out   (mepc_out),
      .irq_en     (irq_en)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic        m_mie_b, m_mpie;
   logic [1:0]  m_mpp;
   logic [31:0] m_mie_reg, m_mscratch, m_mtvec, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cyc, m_ins;
   logic        pend_wr;
   logic [11:0] pend_addr;
   logic [31:0] pend_nv;
   logic        sample_trap;
   logic [31:0] last_rdata;
   logic        last_err;

   logic [11:0] addr_tab [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11,
                                  12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'h345};
   logic [2:0]  f3_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

   function automatic logic [32:0] model_read(input logic [11:0] a);
      case (a)
         12'h300:                   return {1'b1, 19'b0, m_mpp, 3'b0, m_mpie, 3'b0, m_mie_b, 3'b0};
         12'h301:                   return {1'b1, MISA_V};
         12'h304:                   return {1'b1, m_mie_reg};
         12'h305:                   return {1'b1, m_mtvec & ~32'h3};
         12'h340:                   return {1'b1, m_mscratch};
         12'h341:                   return {1'b1, m_mepc & ~32'h1};
         12'h342:                   return {1'b1, m_mcause};
         12'h343:                   return {1'b1, m_mtval};
         12'h344:                   return {1'b1, 32'h0};
         12'hB00, 12'hC00:          return {1'b1, m_cyc[31:0]};
         12'hB80, 12'hC80:          return {1'b1, m_cyc[63:32]};
         12'hB02, 12'hC02:          return {1'b1, m_ins[31:0]};
         12'hB82, 12'hC82:          return {1'b1, m_ins[63:32]};
         12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'h0};
         12'hF14:                   return {1'b1, HART};
         default:                   return {1'b0, 32'h0};
      endcase
   endfunction

   function automatic logic [31:0] new_val(input logic [2:0] f3, input logic [31:0] old, input logic [31:0] op);
      case (f3[1:0])
         2'b01:   return op;
         2'b10:   return old | op;
         2'b11:   return old & ~op;
         default: return old;
      endcase
   endfunction

   function automatic logic [63:0] counter_next(input logic [63:0] cur, input logic wr,
                                                input logic [11:0] a, input logic [11:0] lo_addr,
                                                input logic [31:0] nv, input logic inc);
      if (wr && a == lo_addr) return {cur[63:32], nv};
      if (wr && a == (lo_addr | 12'h080)) return {nv, cur[31:0]};
      return cur + (inc ? 64'd1 : 64'd0);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mie_b <= 1'b0; m_mpie <= 1'b0; m_mpp <= 2'b11;
         m_mie_reg <= '0; m_mscratch <= '0; m_mtvec <= '0;
         m_mepc <= '0; m_mcause <= '0; m_mtval <= '0;
         m_cyc <= '0; m_ins <= '0;
      end else begin
         m_cyc <= counter_next(m_cyc, pend_wr, pend_addr, 12'hB00, pend_nv, 1'b1);
         m_ins <= counter_next(m_ins, pend_wr, pend_addr, 12'hB02, pend_nv, retire);
         if (pend_wr) begin
            case (pend_addr)
               12'h300: begin
                  m_mie_b <= pend_nv[3];
                  m_mpie  <= pend_nv[7];
                  if (pend_nv[12:11] == 2'b00 || pend_nv[12:11] == 2'b11) m_mpp <= pend_nv[12:11];
               end
               12'h304: m_mie_reg  <= pend_nv;
               12'h305: m_mtvec    <= pend_nv;
               12'h340: m_mscratch <= pend_nv;
               12'h341: m_mepc     <= pend_nv;
               12'h342: m_mcause   <= pend_nv;
               12'h343: m_mtval    <= pend_nv;
               default: ;
            endcase
         end
         if (trap) begin
            m_mepc   <= trap_pc;
            m_mcause <= trap_cause;
            m_mtval  <= trap_tval;
            m_mpie   <= m_mie_b;
            m_mie_b  <= 1'b0;
            m_mpp    <= (bus.privilege == 2'b11) ? 2'b11 : 2'b00;
         end else if (mret) begin
            m_mie_b <= m_mpie;
            m_mpie  <= 1'b1;
            m_mpp   <= 2'b00;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_mtvec_out"}, mtvec_out, m_mtvec & ~32'h3);
      check({tag, "_mepc_out"}, mepc_out, m_mepc & ~32'h1);
      check({tag, "_irq_en"}, {31'b0, irq_en}, {31'b0, m_mie_b});
   endtask

   // Issue one access from a negedge; returns at the negedge after the response has cleared.
   task automatic csr_access(input string tag, input logic [11:0] a, input logic [2:0] f3,
                             input logic [31:0] op, input logic w, input logic [1:0] pv,
                             input logic ret);
      logic [32:0] rd;
      logic        legal;
      rd    = model_read(a);
      legal = rd[32] && (a[9:8] <= pv) && !(w && a[11:10] == 2'b11);
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.funct3 = f3;
      bus.operand = op; bus.privilege = pv;
      retire = ret;
      trap   = sample_trap;
      pend_wr = legal && w; pend_addr = a; pend_nv = new_val(f3, rd[31:0], op);
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0; retire = 1'b0; trap = 1'b0; pend_wr = 1'b0;
      check({tag, "_ack"}, {31'b0, bus.ack}, 32'd1);
      check({tag, "_err"}, {31'b0, bus.err}, {31'b0, !legal});
      check({tag, "_rdata"}, bus.rdata, legal ? rd[31:0] : 32'h0);
      last_rdata = bus.rdata;
      last_err   = bus.err;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ack_low"}, {31'b0, bus.ack}, 32'd0);
      check_outputs(tag);
   endtask

   task automatic pulse(input logic do_trap, input logic do_mret);
      trap = do_trap; mret = do_mret;
      @(posedge clk);
      @(negedge clk);
      trap = 1'b0; mret = 1'b0;
   endtask

   initial begin
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.funct3 = '0;
      bus.operand = '0; bus.privilege = 2'b11;
      retire = 1'b0; trap = 1'b0; mret = 1'b0;
      trap_cause = '0; trap_pc = '0; trap_tval = '0;
      pend_wr = 1'b0; pend_addr = '0; pend_nv = '0; sample_trap = 1'b0;
      last_rdata = '0; last_err = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ack", {31'b0, bus.ack}, 32'd0);
      check("rst_err", {31'b0, bus.err}, 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      check_outputs("rst");

      @(negedge clk);
      @(negedge clk);
      csr_access("rd_mcycle", 12'hB00, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mcycle_since_reset", last_rdata, 32'd2);
      csr_access("rd_misa", 12'h301, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("misa_value", last_rdata, MISA_V);
      csr_access("rd_mstatus_rst", 12'h300, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mstatus_rst_mpp", last_rdata, 32'h0000_1800);

      csr_access("rw_mscratch", 12'h340, 3'b001, 32'hDEADBEEF, 1'b1, 2'b11, 1'b0);
      check("mscratch_old", last_rdata, 32'h0);
      csr_access("rs_mscratch", 12'h340, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mscratch_rd", last_rdata, 32'hDEADBEEF);
      csr_access("rc_mscratch", 12'h340, 3'b011, 32'h0000FFFF, 1'b1, 2'b11, 1'b0);
      csr_access("rs_mscratch2", 12'h340, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mscratch_clr", last_rdata, 32'hDEAD0000);

      csr_access("wr_cycle_ro", 12'hC00, 3'b001, 32'h1234, 1'b1, 2'b11, 1'b0);
      check("cycle_ro_err", {31'b0, last_err}, 32'd1);
      csr_access("rd_mstatus_u", 12'h300, 3'b010, 32'h0, 1'b0, 2'b00, 1'b0);
      check("mstatus_u_err", {31'b0, last_err}, 32'd1);
      csr_access("rd_mhartid", 12'hF14, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mhartid", last_rdata, HART);

      csr_access("wr_mcycleh", 12'hB80, 3'b001, 32'h0, 1'b1, 2'b11, 1'b0);
      csr_access("wr_mcycle", 12'hB00, 3'b001, 32'hFFFFFFFF, 1'b1, 2'b11, 1'b0);
      csr_access("rd_mcycleh", 12'hB80, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mcycle_carry", last_rdata, 32'd1);
      csr_access("wr_minstret", 12'hB02, 3'b001, 32'h0000_0100, 1'b1, 2'b11, 1'b1);
      csr_access("rd_minstret", 12'hB02, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("minstret_wr_wins", last_rdata, 32'h0000_0100);

      csr_access("set_mie", 12'h300, 3'b010, 32'h8, 1'b1, 2'b11, 1'b0);
      check("irq_en_set", {31'b0, irq_en}, 32'd1);
      trap_cause = 32'h0000000B; trap_pc = 32'h00001235; trap_tval = $urandom;
      pulse(1'b1, 1'b0);
      check("trap_mepc", mepc_out, 32'h00001234);
      check("trap_irq_en", {31'b0, irq_en}, 32'd0);
      csr_access("rd_mstatus_trap", 12'h300, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("trap_mpie", {31'b0, last_rdata[7]}, 32'd1);
      csr_access("rd_mcause", 12'h342, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("trap_mcause", last_rdata, 32'h0000000B);
      pulse(1'b0, 1'b1);
      check("mret_irq_en", {31'b0, irq_en}, 32'd1);
      csr_access("rd_mstatus_mret", 12'h300, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mret_mpp", {30'b0, last_rdata[12:11]}, 32'd0);

      pulse(1'b1, 1'b1);
      check("trap_beats_mret", {31'b0, irq_en}, 32'd0);
      trap_pc = 32'h0000_2000;
      sample_trap = 1'b1;
      csr_access("mepc_vs_trap", 12'h341, 3'b001, 32'h0000_5555, 1'b1, 2'b11, 1'b0);
      sample_trap = 1'b0;
      check("trap_beats_write", mepc_out, 32'h0000_2000);

      for (int i = 0; i < 40; i++) begin
         csr_access($sformatf("rnd%0d", i), addr_tab[$urandom_range(0, 23)],
                    f3_tab[$urandom_range(0, 5)], $urandom, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 12'h340; bus.funct3 = 3'b001;
      bus.operand = 32'hCAFEF00D; bus.privilege = 2'b11;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_resp_ack", {31'b0, bus.ack}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_with_req_ack", {31'b0, bus.ack}, 32'd0);
      rst = 1'b0; bus.req = 1'b0;
      csr_access("rd_mscratch_post_rst", 12'h340, 3'b010, 32'h0, 1'b0, 2'b11, 1'b0);
      check("mscratch_post_rst", last_rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
